serial_bit_tx: RTL and testbench

Serial bit-stream transmitter. Accepts a parallel word over a valid/ready handshake and shifts it out on a single line: start bit, data LSB-first, stop bit. Each bit is held for a fixed number of clocks. Drives the bit_in side of the team's serial-receive FSMs and is the stimulus source for them in system tests.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_bit_timer.sv | 38 +++
 rtl/serial_bit_tx.sv | 150 +++++++++++++++
 tb/tb_serial_bit_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Encodings shared by the serial transmitter and the serial-receive FSMs.
// The line encoding and state values must stay identical on both sides.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int PARITY_MAX_W = 64;

  // Even parity over a word zero-extended to PARITY_MAX_W bits.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit cycle timer: counts BIT_CYCLES clocks per line bit while enabled.
// The counter is held at zero while enable is low.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_first,
  output logic bit_last,
  output logic last_next
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_r;

  assign bit_last  = (cnt_r == CW'(BIT_CYCLES - 1));
  // bit_first: the following cycle is the first cycle of a bit (counter restarts).
  assign bit_first = !enable || bit_last;
  // last_next: the following cycle is the last cycle of the current bit.
  assign last_next = (BIT_CYCLES == 1) ? 1'b1
                   : (enable && (cnt_r == CW'(BIT_CYCLES - 2)));

  // Cycle counter, wraps at the bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (!enable || bit_last) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/serial_bit_tx.sv
// Serial bit-stream transmitter: start bit, DATA_W bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  serial_state_e     state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic              line_s;
  logic              busy_r, tx_ready_r, bit_out_r, bit_strobe_r, frame_done_r;
  logic              bit_first_s, bit_last_s, last_next_s;
  logic              data_end_s;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_r;
`endif

  serial_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (busy_r),
    .bit_first (bit_first_s),
    .bit_last  (bit_last_s),
    .last_next (last_next_s)
  );

  assign data_end_s = bit_last_s && (idx_r == IW'(DATA_W - 1));

  // Next state, shift register and bit index.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        idx_s = {IW{1'b0}};
        if (tx_valid) begin
          state_s = ST_START;
          shift_s = tx_data;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_last_s) state_s = ST_DATA;
        else            state_s = ST_START;
      end
      ST_DATA: begin
        if (data_end_s) begin
`ifdef SERIAL_TX_PARITY_EN
          state_s = ST_PARITY;
`else
          state_s = ST_STOP;
`endif
          idx_s = {IW{1'b0}};
        end else if (bit_last_s) begin
          shift_s = shift_r >> 1'b1;
          idx_s   = idx_r + IW'(1);
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_last_s) state_s = ST_STOP;
        else            state_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (bit_last_s) state_s = ST_IDLE;
        else            state_s = ST_STOP;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {IW{1'b0}};
      end
    endcase
  end

  // Line value for the coming cycle, so bit_out can be a flop.
  always_comb begin
    line_s = LINE_IDLE;
    case (state_s)
      ST_IDLE:   line_s = LINE_IDLE;
      ST_START:  line_s = LINE_START;
      ST_DATA:   line_s = shift_s[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: line_s = parity_r;
`endif
      ST_STOP:   line_s = LINE_IDLE;
      default:   line_s = LINE_IDLE;
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity of the word, captured on the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && tx_valid) begin
      parity_r <= even_parity(PARITY_MAX_W'(tx_data));
    end
  end
`endif

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shift_r      <= {DATA_W{1'b0}};
      idx_r        <= {IW{1'b0}};
      busy_r       <= 1'b0;
      tx_ready_r   <= 1'b1;
      bit_out_r    <= LINE_IDLE;
      bit_strobe_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      idx_r        <= idx_s;
      busy_r       <= (state_s != ST_IDLE);
      tx_ready_r   <= (state_s == ST_IDLE);
      bit_out_r    <= line_s;
      bit_strobe_r <= (state_s != ST_IDLE) && bit_first_s;
      frame_done_r <= (state_s == ST_STOP) && last_next_s;
    end
  end

  assign tx_ready   = tx_ready_r;
  assign bit_out    = bit_out_r;
  assign bit_strobe = bit_strobe_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: a BIT_CYCLES=4 instance and a BIT_CYCLES=1 instance.
// Expected frames are written out by hand as {stop, [parity,] data, start}.
module tb_serial_bit_tx;

  localparam int DW = 8;
  localparam int BC = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready, bit_out, bit_strobe, busy, frame_done;
  logic [DW-1:0] tx_data1 = 8'h00;
  logic          tx_valid1 = 1'b0;
  logic          tx_ready1, bit_out1, bit_strobe1, busy1, frame_done1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] frame;
    bit            keep;
    bit            b2b;
  } vec_t;
  vec_t vecs[4];

  serial_bit_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bit_out(bit_out), .bit_strobe(bit_strobe),
    .busy(busy), .frame_done(frame_done)
  );

  serial_bit_tx #(.DATA_W(DW), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .bit_out(bit_out1), .bit_strobe(bit_strobe1),
    .busy(busy1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Send one frame on dut and check every cycle of it plus the following idle cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [NB-1:0] exp,
                           input bit keep, input bit b2b);
    logic [NB-1:0] got;
    int waited, hold_err, strobe_err, n_strobe, n_done, done_at, hs_err, bi, c;
    got = '0; waited = 0; hold_err = 0; strobe_err = 0; n_strobe = 0;
    n_done = 0; done_at = 0; hs_err = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !tx_ready; i++) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_handshake"}, 64'(tx_ready), 64'd1);
    if (b2b) check({name, "_gap_cycles"}, 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
    tx_data = ~d;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      bi = (k - 1) / BC;
      c  = (k - 1) % BC;
      if (c == 0) got[bi] = bit_out;
      else if (bit_out !== got[bi]) hold_err++;
      if (bit_strobe !== (c == 0)) strobe_err++;
      if (bit_strobe === 1'b1) n_strobe++;
      if (frame_done === 1'b1) begin
        n_done++;
        done_at = k;
      end
      if (busy !== 1'b1 || tx_ready !== 1'b0) hs_err++;
    end
    @(negedge clk);
    check({name, "_line_bits"}, 64'(got), 64'(exp));
    check({name, "_bit_hold"}, 64'(hold_err), 64'd0);
    check({name, "_strobe_count"}, 64'(n_strobe), 64'(NB));
    check({name, "_strobe_position"}, 64'(strobe_err), 64'd0);
    check({name, "_frame_done_cycle"}, 64'(done_at), 64'(FL));
    check({name, "_frame_done_count"}, 64'(n_done), 64'd1);
    check({name, "_busy_not_ready"}, 64'(hs_err), 64'd0);
    check({name, "_idle_after"}, 64'({tx_ready, busy, bit_out, bit_strobe, frame_done}), 64'(5'b10100));
  endtask

  // Start a frame, then assert reset during cycle cyc after the handshake.
  task automatic abort_frame(input string name, input logic [7:0] d, input int cyc, input logic exp_line);
    int n_done;
    n_done   = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
    check({name, "_handshake"}, 64'(tx_ready), 64'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= cyc; k++) @(negedge clk);
    check({name, "_line_before_reset"}, 64'(bit_out), 64'(exp_line));
    #1 reset = 1'b1;
    #1;
    check({name, "_async_reset"}, 64'({bit_out, busy, tx_ready}), 64'(3'b101));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) n_done++;
    end
    reset = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) n_done++;
    end
    check({name, "_no_frame_done"}, 64'(n_done), 64'd0);
    check({name, "_idle_after"}, 64'({tx_ready, busy, bit_out}), 64'(3'b101));
  endtask

  initial begin
    logic [NB-1:0] got1, exp81, exp01;
    int ns1, nd1, da1, waited1;
`ifdef SERIAL_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0, 1'b0, 1'b1};
    vecs[3] = '{8'h07, 11'b1_1_00000111_0, 1'b0, 1'b0};
    exp81   = 11'b1_0_10000001_0;
    exp01   = 11'b1_1_00000001_0;
`else
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0, 1'b1};
    vecs[3] = '{8'h07, 10'b1_00000111_0, 1'b0, 1'b0};
    exp81   = 10'b1_10000001_0;
    exp01   = 10'b1_00000001_0;
`endif

    repeat (3) @(negedge clk);
    check("reset_state", 64'({bit_out, tx_ready, busy, bit_strobe, frame_done}), 64'(5'b11000));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), 64'({bit_out, tx_ready, busy, bit_strobe, frame_done}), 64'(5'b11000));
    end

    for (int v = 0; v < 4; v++)
      run_frame($sformatf("vec%0d_%02h", v, vecs[v].data), vecs[v].data, vecs[v].frame, vecs[v].keep, vecs[v].b2b);

    abort_frame("abort_c15", 8'h3C, 15, 1'b1);
    abort_frame("abort_c3", 8'h3C, 3, 1'b0);
    run_frame("after_reset_81", 8'h81, exp81, 1'b0, 1'b0);

    // Single-cycle bits on dut1.
    got1 = '0; ns1 = 0; nd1 = 0; da1 = 0; waited1 = 0;
    tx_data1  = 8'h01;
    tx_valid1 = 1'b1;
    for (int i = 0; i < 100 && !tx_ready1; i++) begin
      @(negedge clk);
      waited1++;
    end
    check("bc1_handshake", 64'(tx_ready1), 64'd1);
    @(posedge clk);
    #1;
    tx_valid1 = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      @(negedge clk);
      got1[k-1] = bit_out1;
      if (bit_strobe1 === 1'b1) ns1++;
      if (frame_done1 === 1'b1) begin
        nd1++;
        da1 = k;
      end
    end
    check("bc1_line_bits", 64'(got1), 64'(exp01));
    check("bc1_strobe_count", 64'(ns1), 64'(NB));
    check("bc1_frame_done_cycle", 64'(da1), 64'(NB));
    check("bc1_frame_done_count", 64'(nd1), 64'd1);
    @(negedge clk);
    check("bc1_idle_after", 64'({tx_ready1, busy1, bit_out1, bit_strobe1}), 64'(4'b1010));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
